// File: rtl/acm_err_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : acm_err_monitor_if
// Description : Report, event-drain and status signals of the ACM error monitor.
// Revision    : 1.0 - initial release
// ============================================================================
interface acm_err_monitor_if #(
    parameter int CNT_W = 16
);
    logic             s_valid_i;
    logic [1:0]       s_ce_i;
    logic [1:0]       s_uce_i;
    logic [4:0]       s_r_p1_add_i;
    logic [4:0]       s_r_p2_add_i;
    logic             s_clear_i;
    logic             s_ev_valid_o;
    logic [6:0]       s_ev_o;
    logic             s_ev_ready_i;
    logic [CNT_W-1:0] s_ce_cnt_o;
    logic [CNT_W-1:0] s_uce_cnt_o;
    logic             s_ovf_o;
    logic             s_irq_o;

    modport master (
        output s_valid_i, s_ce_i, s_uce_i, s_r_p1_add_i, s_r_p2_add_i, s_clear_i, s_ev_ready_i,
        input  s_ev_valid_o, s_ev_o, s_ce_cnt_o, s_uce_cnt_o, s_ovf_o, s_irq_o
    );

    modport slave (
        input  s_valid_i, s_ce_i, s_uce_i, s_r_p1_add_i, s_r_p2_add_i, s_clear_i, s_ev_ready_i,
        output s_ev_valid_o, s_ev_o, s_ce_cnt_o, s_uce_cnt_o, s_ovf_o, s_irq_o
    );
endinterface
`default_nettype wire

// File: rtl/acm_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : acm_err_monitor
// Description : Counts ACM CE/UCE reports, queues event records, raises sticky irq.
// Revision    : 1.0 - initial release
// ============================================================================
module acm_err_monitor #(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CE_THR     = 8
) (
    input  wire logic         s_clk_i,
    input  wire logic         s_resetn_i,
    acm_err_monitor_if.slave  bus
);
    localparam int               c_AW  = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_THR = CNT_W'(CE_THR);

    logic [6:0]       r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW:0]    r_count;
    logic             r_ev_valid;
    logic [6:0]       r_ev;
    logic [CNT_W-1:0] r_ce_cnt;
    logic [CNT_W-1:0] r_uce_cnt;
    logic             r_ovf;
    logic             r_irq;

    logic             w_ev1;
    logic             w_ev2_raw;
    logic             w_dup;
    logic             w_ev2;
    logic [6:0]       w_rec0;
    logic [6:0]       w_rec1;
    logic [1:0]       w_n_ev;
    logic [1:0]       w_ce_inc;
    logic [1:0]       w_uce_inc;
    logic             w_pop;
    logic [c_AW+1:0]  w_free;
    logic             w_drop;
    logic [1:0]       w_n_push;
    logic [CNT_W-1:0] w_ce_nxt;
    logic [CNT_W-1:0] w_uce_nxt;
    logic             w_irq_set;
    logic [c_AW-1:0]  w_rd_nxt;
    logic [c_AW-1:0]  w_wr_ptr1;
    logic [c_AW:0]    w_count_nxt;
    logic [6:0]       w_head_nxt;

    function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] cnt,
                                                   input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        w_ev1     = bus.s_valid_i & (bus.s_ce_i[0] | bus.s_uce_i[0]);
        w_ev2_raw = bus.s_valid_i & (bus.s_ce_i[1] | bus.s_uce_i[1]);
        // Both ports reporting the same register with the same severity is one fault.
        w_dup     = w_ev1 & w_ev2_raw & (bus.s_r_p1_add_i == bus.s_r_p2_add_i)
                    & (bus.s_uce_i[0] == bus.s_uce_i[1]);
        w_ev2     = w_ev2_raw & ~w_dup;

        w_rec1    = {bus.s_uce_i[1], 1'b1, bus.s_r_p2_add_i};
        w_rec0    = w_ev1 ? {bus.s_uce_i[0], 1'b0, bus.s_r_p1_add_i} : w_rec1;
        w_n_ev    = {1'b0, w_ev1} + {1'b0, w_ev2};
        w_ce_inc  = {1'b0, w_ev1 & ~bus.s_uce_i[0]} + {1'b0, w_ev2 & ~bus.s_uce_i[1]};
        w_uce_inc = {1'b0, w_ev1 &  bus.s_uce_i[0]} + {1'b0, w_ev2 &  bus.s_uce_i[1]};

        w_pop     = (r_count != '0) & bus.s_ev_ready_i;
        w_free    = (c_AW+2)'(FIFO_DEPTH) - {1'b0, r_count} + (c_AW+2)'(w_pop);
        w_drop    = (c_AW+2)'(w_n_ev) > w_free;
        // On a drop there are fewer than two free slots, so free fits in two bits.
        w_n_push  = w_drop ? w_free[1:0] : w_n_ev;

        w_ce_nxt  = f_sat_add(r_ce_cnt, w_ce_inc);
        w_uce_nxt = f_sat_add(r_uce_cnt, w_uce_inc);
        w_irq_set = (w_uce_inc != 2'd0) | ((r_ce_cnt < c_THR) & (w_ce_nxt >= c_THR));

        w_rd_nxt    = r_rd_ptr + c_AW'(w_pop);
        w_wr_ptr1   = r_wr_ptr + c_AW'(1);
        w_count_nxt = r_count + (c_AW+1)'(w_n_push) - (c_AW+1)'(w_pop);
        // The next head is the first record written this cycle when the queue drains to it.
        w_head_nxt  = r_mem[w_rd_nxt];
        if ((w_n_push != 2'd0) && (w_rd_nxt == r_wr_ptr)) begin
            w_head_nxt = w_rec0;
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i || bus.s_clear_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_ev_valid <= 1'b0;
            r_ev       <= '0;
            r_ce_cnt   <= '0;
            r_uce_cnt  <= '0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_n_push != 2'd0) begin
                r_mem[r_wr_ptr] <= w_rec0;
            end
            if (w_n_push == 2'd2) begin
                r_mem[w_wr_ptr1] <= w_rec1;
            end
            r_wr_ptr   <= r_wr_ptr + c_AW'(w_n_push);
            r_rd_ptr   <= w_rd_nxt;
            r_count    <= w_count_nxt;
            r_ev_valid <= (w_count_nxt != '0);
            r_ev       <= w_head_nxt;
            r_ce_cnt   <= w_ce_nxt;
            r_uce_cnt  <= w_uce_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end
        end
    end

    assign bus.s_ev_valid_o = r_ev_valid;
    assign bus.s_ev_o       = r_ev;
    assign bus.s_ce_cnt_o   = r_ce_cnt;
    assign bus.s_uce_cnt_o  = r_uce_cnt;
    assign bus.s_ovf_o      = r_ovf;
    assign bus.s_irq_o      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_acm_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_acm_err_monitor
// Description : Self-checking bench for acm_err_monitor against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acm_err_monitor;
    localparam int CNT_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int CE_THR     = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    acm_err_monitor_if #(.CNT_W(CNT_W)) bus ();

    acm_err_monitor #(
        .CNT_W      (CNT_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CE_THR     (CE_THR)
    ) dut (
        .s_clk_i    (clk),
        .s_resetn_i (rstn),
        .bus        (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [6:0] m_q[$];
    int         m_ce;
    int         m_uce;
    bit         m_ovf;
    bit         m_irq;
    bit         m_after_reset;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_ce  = 0;
        m_uce = 0;
        m_ovf = 0;
        m_irq = 0;
    endtask

    // Applies one clock edge worth of the monitor rules to the model state.
    task automatic model_step();
        logic [6:0] evs[$];
        int         old_ce;
        bit         any_uce;
        if (!rstn) begin
            model_clear();
            m_after_reset = 1;
            return;
        end
        m_after_reset = 0;
        if (bus.s_clear_i) begin
            model_clear();
            return;
        end
        if (bus.s_valid_i && (bus.s_ce_i[0] || bus.s_uce_i[0]))
            evs.push_back({bus.s_uce_i[0], 1'b0, bus.s_r_p1_add_i});
        if (bus.s_valid_i && (bus.s_ce_i[1] || bus.s_uce_i[1]))
            evs.push_back({bus.s_uce_i[1], 1'b1, bus.s_r_p2_add_i});
        if (evs.size() == 2 && evs[0][6] == evs[1][6] && evs[0][4:0] == evs[1][4:0])
            void'(evs.pop_back());
        old_ce  = m_ce;
        any_uce = 0;
        foreach (evs[i]) begin
            if (evs[i][6]) begin
                any_uce = 1;
                if (m_uce < CNT_MAX) m_uce++;
            end else begin
                if (m_ce < CNT_MAX) m_ce++;
            end
        end
        if (any_uce || (old_ce < CE_THR && m_ce >= CE_THR)) m_irq = 1;
        if (m_q.size() > 0 && bus.s_ev_ready_i) void'(m_q.pop_front());
        foreach (evs[i]) begin
            if (m_q.size() < FIFO_DEPTH) m_q.push_back(evs[i]);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        chk("ev_valid", 32'(bus.s_ev_valid_o), 32'(m_q.size() != 0));
        if (m_q.size() != 0)    chk("ev_head", 32'(bus.s_ev_o), 32'(m_q[0]));
        else if (m_after_reset) chk("ev_reset", 32'(bus.s_ev_o), 32'd0);
        chk("ce_cnt",  32'(bus.s_ce_cnt_o),  32'(m_ce));
        chk("uce_cnt", 32'(bus.s_uce_cnt_o), 32'(m_uce));
        chk("ovf",     32'(bus.s_ovf_o),     32'(m_ovf));
        chk("irq",     32'(bus.s_irq_o),     32'(m_irq));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] ce, input logic [1:0] uce,
                         input logic [4:0] p1, input logic [4:0] p2,
                         input logic rdy, input logic clr);
        bus.s_valid_i    = v;
        bus.s_ce_i       = ce;
        bus.s_uce_i      = uce;
        bus.s_r_p1_add_i = p1;
        bus.s_r_p2_add_i = p2;
        bus.s_ev_ready_i = rdy;
        bus.s_clear_i    = clr;
    endtask

    initial begin
        rstn = 1'b0;
        m_after_reset = 0;
        model_clear();
        drive(0, 2'b00, 2'b00, 5'd0, 5'd0, 0, 0);

        // Reset then idle.
        repeat (2) tick();
        rstn = 1'b1;
        repeat (10) tick();
        chk("t1_valid", 32'(bus.s_ev_valid_o), 32'd0);
        chk("t1_ev",    32'(bus.s_ev_o),       32'd0);
        chk("t1_irq",   32'(bus.s_irq_o),      32'd0);

        // Single CE on port 1.
        drive(1, 2'b01, 2'b00, 5'd5, 5'd0, 0, 0);
        tick();
        drive(0, 2'b00, 2'b00, 5'd0, 5'd0, 0, 0);
        chk("t2_ce", 32'(bus.s_ce_cnt_o), 32'd1);
        chk("t2_ev", 32'(bus.s_ev_o),     32'b0_0_00101);
        drive(0, 2'b00, 2'b00, 5'd0, 5'd0, 1, 0);
        tick();
        chk("t2_drained", 32'(bus.s_ev_valid_o), 32'd0);

        // Dedup, then CE+UCE on different ports.
        drive(1, 2'b11, 2'b00, 5'd7, 5'd7, 0, 0);
        tick();
        chk("t3_dedup_ev", 32'(bus.s_ev_o),     32'b0_0_00111);
        chk("t3_dedup_ce", 32'(bus.s_ce_cnt_o), 32'd2);
        drive(0, 2'b00, 2'b00, 5'd0, 5'd0, 1, 0);
        tick();
        drive(1, 2'b01, 2'b10, 5'd3, 5'd9, 0, 0);
        tick();
        drive(0, 2'b00, 2'b00, 5'd0, 5'd0, 1, 0);
        chk("t3_head0", 32'(bus.s_ev_o),      32'b0_0_00011);
        chk("t3_irq",   32'(bus.s_irq_o),     32'd1);
        chk("t3_uce",   32'(bus.s_uce_cnt_o), 32'd1);
        tick();
        chk("t3_head1", 32'(bus.s_ev_o), 32'b1_1_01001);
        tick();

        // Overflow: six CE events into a four-entry FIFO.
        drive(0, 2'b00, 2'b00, 5'd0, 5'd0, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b11, 2'b00, 5'(2 * i), 5'(2 * i + 1), 0, 0);
            tick();
        end
        drive(0, 2'b00, 2'b00, 5'd0, 5'd0, 0, 0);
        chk("t4_ovf",  32'(bus.s_ovf_o),    32'd1);
        chk("t4_ce",   32'(bus.s_ce_cnt_o), 32'd6);
        chk("t4_head", 32'(bus.s_ev_o),     32'b0_0_00000);

        // Pop and push in the same cycle while full.
        drive(1, 2'b01, 2'b00, 5'd20, 5'd0, 1, 0);
        tick();
        drive(0, 2'b00, 2'b00, 5'd0, 5'd0, 1, 0);
        chk("t5_head0", 32'(bus.s_ev_o), 32'b0_1_00001);
        tick();
        chk("t5_head1", 32'(bus.s_ev_o), 32'b0_0_00010);
        tick();
        chk("t5_head2", 32'(bus.s_ev_o), 32'b0_1_00011);
        tick();
        chk("t5_head3", 32'(bus.s_ev_o), 32'b0_0_10100);
        tick();
        chk("t5_empty", 32'(bus.s_ev_valid_o), 32'd0);

        // CE threshold irq, then clear alongside a UCE report.
        drive(0, 2'b00, 2'b00, 5'd0, 5'd0, 0, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 2'b01, 2'b00, 5'(i), 5'd0, 1, 0);
            tick();
            if (i == 6) chk("t6_irq_before", 32'(bus.s_irq_o), 32'd0);
        end
        chk("t6_irq_at", 32'(bus.s_irq_o), 32'd1);
        drive(1, 2'b00, 2'b01, 5'd1, 5'd0, 1, 1);
        tick();
        chk("t6_clr_uce", 32'(bus.s_uce_cnt_o),  32'd0);
        chk("t6_clr_irq", 32'(bus.s_irq_o),      32'd0);
        chk("t6_clr_val", 32'(bus.s_ev_valid_o), 32'd0);

        // Counter saturation.
        for (int i = 0; i < 10; i++) begin
            drive(1, 2'b11, 2'b00, 5'(2 * i), 5'(2 * i + 1), 1, 0);
            tick();
        end
        chk("sat_ce", 32'(bus.s_ce_cnt_o), 32'(CNT_MAX));
        for (int i = 0; i < 10; i++) begin
            drive(1, 2'b00, 2'b11, 5'(2 * i), 5'(2 * i + 1), 1, 0);
            tick();
        end
        chk("sat_uce", 32'(bus.s_uce_cnt_o), 32'(CNT_MAX));

        // Randomized traffic; narrow address range to exercise dedup.
        for (int n = 0; n < 4000; n++) begin
            rstn = ($urandom_range(0, 299) != 0);
            drive(($urandom_range(0, 3) != 0), 2'($urandom),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 99) == 0));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
